// File: rtl/mem_bus_arbiter_if.sv
// Shared memory-bus bundle between the arbiter (master) and the memory/bus slave.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 64
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [63:0]       bus_wdata;
  logic [7:0]        bus_wmask;
  logic              bus_ack;
  logic [63:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one memory bus, one transaction at a time.
// Optional MEM_ARB_RR_EN: round-robin between the two requesters instead of data-first priority.
module mem_bus_arbiter #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_request,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_inst,
  output logic              if_stall,
  input  logic              re_mem,
  input  logic              we_mem,
  input  logic [ADDR_W-1:0] address,
  input  logic [63:0]       wdata_mem,
  input  logic [7:0]        wmask_mem,
  output logic [63:0]       rdata_mem,
  output logic              mem_stall,
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t state_reg;
  logic   if_done_reg;
  logic   data_done_reg;
  logic   fetch_hi_reg;
  logic   data_pend;
  logic   fetch_pend;
  logic   grant_data;
  logic   grant_fetch;
  logic   unused_addr_bits;

  assign unused_addr_bits = ^if_addr[1:0];

  assign data_pend  = (re_mem | we_mem) & ~data_done_reg;
  assign fetch_pend = if_request & ~if_done_reg;

  assign if_stall  = if_request & ~if_done_reg;
  assign mem_stall = (re_mem | we_mem) & ~data_done_reg;

`ifdef MEM_ARB_RR_EN
  logic last_grant_data_reg;
  // On contention the side that was not served last wins.
  assign grant_data = data_pend & (~fetch_pend | ~last_grant_data_reg);
`else
  assign grant_data = data_pend;
`endif
  assign grant_fetch = fetch_pend & ~grant_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_wmask <= '0;
      if_inst       <= 32'h0000_0013;
      rdata_mem     <= '0;
      if_done_reg   <= 1'b0;
      data_done_reg <= 1'b0;
      fetch_hi_reg  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_data_reg <= 1'b1;
`endif
    end else begin
      if_done_reg   <= 1'b0;
      data_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_data) begin
            state_reg     <= DATA;
            bus.bus_req   <= 1'b1;
            bus.bus_addr  <= address;
            bus.bus_we    <= we_mem;
            bus.bus_wdata <= wdata_mem;
            bus.bus_wmask <= we_mem ? wmask_mem : 8'h00;
`ifdef MEM_ARB_RR_EN
            last_grant_data_reg <= 1'b1;
`endif
          end else if (grant_fetch) begin
            state_reg     <= FETCH;
            bus.bus_req   <= 1'b1;
            bus.bus_addr  <= {if_addr[ADDR_W-1:3], 3'b000};
            bus.bus_we    <= 1'b0;
            bus.bus_wmask <= 8'h00;
            // Word select is kept so a core that drops its request still gets the right half.
            fetch_hi_reg  <= if_addr[2];
`ifdef MEM_ARB_RR_EN
            last_grant_data_reg <= 1'b0;
`endif
          end
        end
        FETCH: begin
          if (bus.bus_ack) begin
            state_reg   <= IDLE;
            bus.bus_req <= 1'b0;
            if_done_reg <= 1'b1;
            if_inst     <= fetch_hi_reg ? bus.bus_rdata[63:32] : bus.bus_rdata[31:0];
          end
        end
        DATA: begin
          if (bus.bus_ack) begin
            state_reg     <= IDLE;
            bus.bus_req   <= 1'b0;
            data_done_reg <= 1'b1;
            if (!bus.bus_we) rdata_mem <= bus.bus_rdata;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized self-checking bench for mem_bus_arbiter; the bench also plays the bus slave.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_request;
  logic [63:0] if_addr;
  logic [31:0] if_inst;
  logic        if_stall;
  logic        re_mem;
  logic        we_mem;
  logic [63:0] address;
  logic [63:0] wdata_mem;
  logic [7:0]  wmask_mem;
  logic [63:0] rdata_mem;
  logic        mem_stall;

  int vec_count = 0;
  int err_count = 0;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Reference model state: what software-visible results should be.
  bit          last_grant_data;
  logic [31:0] exp_if_inst;
  logic [63:0] exp_rdata;

  mem_bus_arbiter_if #(.ADDR_W(64)) bus_if ();

  mem_bus_arbiter #(.ADDR_W(64)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .if_request (if_request),
    .if_addr    (if_addr),
    .if_inst    (if_inst),
    .if_stall   (if_stall),
    .re_mem     (re_mem),
    .we_mem     (we_mem),
    .address    (address),
    .wdata_mem  (wdata_mem),
    .wmask_mem  (wmask_mem),
    .rdata_mem  (rdata_mem),
    .mem_stall  (mem_stall),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    last_grant_data = 1'b1;
    exp_if_inst     = 32'h0000_0013;
    exp_rdata       = 64'h0;
  endtask

  // One scenario: optional fetch and optional data request; timing predicted from the rules
  // request->grant edge, 1+waits bus cycles, done cycle right after the ack.
  task automatic run_txn(input bit do_f, input logic [63:0] fa, input int wf,
                         input logic [63:0] fr, input bit f_drop,
                         input bit do_d, input int dd, input bit we, input logic [63:0] da,
                         input logic [63:0] wdat, input logic [7:0] wm, input int wdw,
                         input logic [63:0] dr, input bit noise);
    bit data_first;
    int f_done, d_done, last;
    bit f_act, d_act, in_f, in_d;
    f_done = 0;
    d_done = 0;
    if (do_f && do_d) begin
      if (dd > 0) data_first = 1'b0;
      else data_first = RR ? !last_grant_data : 1'b1;
      if (data_first) begin
        d_done = 3 + wdw;
        f_done = 5 + wdw + wf;
      end else begin
        f_done = 3 + wf;
        d_done = 5 + wf + wdw;
      end
      last_grant_data = !data_first;
    end else if (do_f) begin
      f_done = 3 + wf;
      last_grant_data = 1'b0;
    end else if (do_d) begin
      d_done = 3 + dd + wdw;
      last_grant_data = 1'b1;
    end
    last = (f_done > d_done) ? f_done : d_done;
    if (do_f) exp_if_inst = fa[2] ? fr[63:32] : fr[31:0];
    if (do_d && !we) exp_rdata = dr;
    $display("txn fetch=%0d addr=%h wf=%0d drop=%0d | data=%0d we=%0d addr=%h delay=%0d wd=%0d",
             do_f, fa, wf, f_drop, do_d, we, da, dd, wdw);
    if_addr   = fa;
    address   = da;
    wdata_mem = wdat;
    wmask_mem = wm;
    for (int cyc = 1; cyc <= last + 2; cyc++) begin
      f_act = do_f && (f_drop ? (cyc == 1) : (cyc <= f_done));
      d_act = do_d && (cyc > dd) && (cyc <= d_done);
      if_request = f_act;
      re_mem     = d_act && !we;
      we_mem     = d_act && we;
      #1;
      in_f = do_f && (cyc >= f_done - 1 - wf) && (cyc <= f_done - 1);
      in_d = do_d && (cyc >= d_done - 1 - wdw) && (cyc <= d_done - 1);
      check("if_stall", if_stall, f_act && (cyc != f_done));
      check("mem_stall", mem_stall, d_act && (cyc != d_done));
      check("bus_req", bus_if.bus_req, in_f || in_d);
      if (in_f) begin
        check("fetch_addr", bus_if.bus_addr, {fa[63:3], 3'b000});
        check("fetch_we", bus_if.bus_we, 1'b0);
        check("fetch_wmask", bus_if.bus_wmask, 8'h00);
      end
      if (in_d) begin
        check("data_addr", bus_if.bus_addr, da);
        check("data_we", bus_if.bus_we, we);
        check("data_wdata", bus_if.bus_wdata, wdat);
        check("data_wmask", bus_if.bus_wmask, we ? wm : 8'h00);
      end
      if (do_f && cyc == f_done) check("if_inst", if_inst, exp_if_inst);
      if (do_d && cyc == d_done) check("rdata_mem", rdata_mem, exp_rdata);
      if (in_f && cyc == f_done - 1) begin
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = fr;
      end else if (in_d && cyc == d_done - 1) begin
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = dr;
      end else begin
        bus_if.bus_ack   = (!(in_f || in_d) && noise) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_if.bus_rdata = {$urandom, $urandom};
      end
      @(posedge clk);
      #1;
    end
    bus_if.bus_ack = 1'b0;
    if_request     = 1'b0;
    re_mem         = 1'b0;
    we_mem         = 1'b0;
  endtask

  initial begin
    int mode, wf, wdw, dd;
    bit we, drop;
    rstn = 1'b0;
    if_request = 1'b0; if_addr = '0;
    re_mem = 1'b0; we_mem = 1'b0; address = '0; wdata_mem = '0; wmask_mem = '0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus_req", bus_if.bus_req, 1'b0);
    check("rst_bus_we", bus_if.bus_we, 1'b0);
    check("rst_bus_addr", bus_if.bus_addr, 64'h0);
    check("rst_bus_wdata", bus_if.bus_wdata, 64'h0);
    check("rst_bus_wmask", bus_if.bus_wmask, 8'h00);
    check("rst_if_inst", if_inst, 32'h0000_0013);
    check("rst_rdata_mem", rdata_mem, 64'h0);
    check("rst_if_stall", if_stall, 1'b0);
    check("rst_mem_stall", mem_stall, 1'b0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Isolated fetch, two wait states.
    run_txn(1, 64'h1004, 2, 64'hAAAA_BBBB_0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Store; bus read data must not reach rdata_mem.
    run_txn(0, 0, 0, 0, 0, 1, 0, 1, 64'h2008, 64'h55, 8'h0F, 0, 64'hDEAD_BEEF_CAFE_F00D, 0);
    // Simultaneous fetch and load.
    run_txn(1, 64'h4000, 1, 64'h1111_2222_3333_4444, 0,
            1, 0, 0, 64'h5000, 64'h0, 8'hFF, 1, 64'h0123_4567_89AB_CDEF, 0);
    // Load arriving during a fetch whose ack is delayed four cycles.
    run_txn(1, 64'h6004, 4, 64'h7777_6666_5555_4444, 0,
            1, 1, 0, 64'h7010, 64'h0, 8'h00, 0, 64'hFEDC_BA98_7654_3210, 0);
    // Fetch request withdrawn right after the grant.
    run_txn(1, 64'h8000, 3, 64'h9999_8888_ABCD_1234, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset while a data transaction holds the bus.
    address = 64'h3000; re_mem = 1'b1;
    #1;
    check("pre_rst_mem_stall", mem_stall, 1'b1);
    @(posedge clk);
    #2;
    check("pre_rst_bus_req", bus_if.bus_req, 1'b1);
    rstn = 1'b0;
    #1;
    check("async_rst_bus_req", bus_if.bus_req, 1'b0);
    check("async_rst_bus_addr", bus_if.bus_addr, 64'h0);
    check("async_rst_mem_stall", mem_stall, 1'b1);
    @(posedge clk);
    #1;
    check("in_rst_bus_req", bus_if.bus_req, 1'b0);
    model_reset();
    rstn = 1'b1;
    run_txn(0, 0, 0, 0, 0, 1, 0, 0, 64'h3000, 64'h0, 8'h00, 1, 64'h0BAD_F00D_1234_5678, 0);

    for (int n = 0; n < 60; n++) begin
      mode = $urandom_range(0, 3);
      wf   = $urandom_range(0, 3);
      wdw  = $urandom_range(0, 3);
      dd   = (mode == 3) ? $urandom_range(1, 1 + wf) : 0;
      we   = 1'($urandom_range(0, 1));
      drop = (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_txn(mode != 1, {$urandom, $urandom}, wf, {$urandom, $urandom}, drop,
              mode != 0, dd, we, {$urandom, $urandom}, {$urandom, $urandom},
              8'($urandom), wdw, {$urandom, $urandom}, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning the width of every address port.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port if_request, input, 1, fetch request, held by the core until if_stall is low.
REQ-005 SHALL have port if_addr, input, ADDR_W, fetch byte address; bits [1:0] are ignored.
REQ-006 SHALL have port if_inst, output, 32, fetched instruction.
REQ-007 SHALL have port if_stall, output, 1, fetch not yet complete.
REQ-008 SHALL have the following data-request input ports: re_mem (1), we_mem (1), address (ADDR_W), wdata_mem (64), wmask_mem (8); the data request is held until mem_stall is low.
REQ-009 SHALL have port rdata_mem, output, 64, load data.
REQ-010 SHALL have port mem_stall, output, 1, data access not yet complete.
REQ-011 SHALL have the following bus output ports: bus_req (1), bus_we (1), bus_addr (ADDR_W), bus_wdata (64), bus_wmask (8).
REQ-012 SHALL have the following bus input ports: bus_ack (1), bus_rdata (64).

Function
REQ-013 SHALL implement FSM states IDLE, FETCH and DATA.
REQ-014 IDLE SHALL act on pending requests as follows:
- A data request is pending when (re_mem|we_mem) and data_done=0; a fetch request is pending when if_request and if_done=0.
- Default arbitration SHALL be fixed priority, DATA over FETCH.
- On the grant edge: state→FETCH/DATA, bus_req<=1, and the bus fields are latched.
REQ-015 FETCH latch SHALL set bus_addr={if_addr[ADDR_W-1:3],3'b000}, bus_we=0, bus_wmask=0.
REQ-016 DATA latch SHALL set bus_addr=address, bus_we=we_mem, bus_wdata=wdata_mem, bus_wmask=we_mem?wmask_mem:0.
REQ-017 FETCH/DATA SHALL hold bus_req and all bus fields stable until the edge on which bus_ack=1. On that edge:
- bus_req<=0 and state→IDLE.
- Done pulse: if_done<=1 (FETCH) or data_done<=1 (DATA).
REQ-018 SHALL capture on the ack edge of FETCH: if_inst<= if_addr[2] ? bus_rdata[63:32] : bus_rdata[31:0].
REQ-019 SHALL capture on the ack edge of a DATA read: rdata_mem<=bus_rdata; on a DATA write, rdata_mem SHALL be unchanged.
REQ-020 SHALL hold if_done and data_done high for exactly one cycle.
REQ-021 SHALL drive if_stall = if_request & ~if_done and mem_stall = (re_mem|we_mem) & ~data_done, combinationally.
REQ-022 Minimum latency SHALL be 3 cycles from the request to the cycle with stall low, given bus_ack in the first bus_req cycle; each extra wait cycle adds one cycle.
REQ-023 SHALL ignore bus_ack while in IDLE.
REQ-024 A requester that drops its request mid-transaction SHALL NOT abort the bus transaction: the transaction completes, data is captured, and the done pulse is produced.
REQ-025 SHALL NOT re-grant the same request during the cycle its done pulse is high; the other requester MAY be granted in that cycle.
REQ-026 SHALL NOT take a new grant while bus_req is high, which implies at most one outstanding bus transaction.

Reset
REQ-027 While rstn=0, outputs SHALL asynchronously take: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wmask=0, if_inst=32'h00000013, rdata_mem=0, if_done=0, data_done=0, last_grant=DATA.
REQ-028 Reset mid-transaction SHALL drop bus_req immediately, discard the transaction, and produce no done pulse after release.

Configuration
REQ-029 SHALL support macro MEM_ARB_RR_EN.
- Defined: when both requests are pending in IDLE, grant the requester opposite to last_grant; last_grant SHALL update on every grant.
- Undefined: fixed DATA-over-FETCH priority, and last_grant is not implemented.

Verification
REQ-030 Bench SHALL cover an isolated fetch: if_request=1, if_addr=0x1004, bus_ack after 2 wait cycles with bus_rdata=0xAAAA_BBBB_0000_0013 -> bus_addr=0x1000, if_inst=0xAAAABBBB, if_stall low in cycle 5 only.
REQ-031 Bench SHALL cover a store: we_mem=1, address=0x2008, wmask_mem=0x0F, wdata_mem=0x55 -> bus_we=1, bus_wmask=0x0F, bus_wdata=0x55, rdata_mem unchanged, mem_stall low for one cycle.
REQ-032 Bench SHALL cover a simultaneous fetch and load, macro undefined -> DATA granted first and FETCH granted in the data_done cycle; with MEM_ARB_RR_EN after reset (last_grant=DATA) -> FETCH granted first.
REQ-033 Bench SHALL cover a load arriving during FETCH with bus_ack delayed 4 cycles -> mem_stall=1 throughout, DATA granted only after if_done, bus fields stable during the wait.
REQ-034 Bench SHALL cover rstn pulled low while bus_req=1 in DATA -> bus_req=0 immediately, no data_done after release, and the next request is granted normally.
REQ-035 Bench SHALL cover if_request dropped one cycle after grant, with bus_ack later -> transaction completes once, no re-grant, FSM returns to IDLE.
